// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter: one owner at a time, rotating priority, hold timeout.
// Latency: request seen at edge k is granted after edge k+1; at least one idle cycle between grants.
// Backpressure: none; an owner keeps the grant until release_i, dropping req, or MAX_HOLD cycles.
module rr_grant_arbiter #(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 16,
    localparam int IDX_W   = $clog2(N_REQ),
    localparam int CNT_W   = $clog2(MAX_HOLD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             release_i,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout,
    output logic [IDX_W-1:0] ptr
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [N_REQ-1:0]   gnt_d;
    logic [IDX_W-1:0]   idx_d;
    logic               valid_d;
    logic               timeout_d;
    logic [IDX_W-1:0]   ptr_d;
    logic [CNT_W-1:0]   hold_q;
    logic [CNT_W-1:0]   hold_d;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   ptr_after_owner;
    int                 cand;

    // Scan ptr, ptr+1, ... wrapping at N_REQ (not at 2**IDX_W) so non-power-of-two sizes work.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!sel_found && req[IDX_W'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    assign ptr_after_owner = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt;
        idx_d     = gnt_idx;
        valid_d   = gnt_valid;
        timeout_d = 1'b0;
        ptr_d     = ptr;
        hold_d    = hold_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = GRANT;
                    gnt_d   = N_REQ'(1) << sel_idx;
                    idx_d   = sel_idx;
                    valid_d = 1'b1;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (release_i || !req[gnt_idx] || (hold_q == CNT_W'(MAX_HOLD - 1))) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    valid_d   = 1'b0;
                    ptr_d     = ptr_after_owner;
                    hold_d    = '0;
                    // Only a revocation the owner did not ask for counts as a timeout.
                    timeout_d = !release_i && req[gnt_idx];
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt       <= gnt_d;
            gnt_idx   <= idx_d;
            gnt_valid <= valid_d;
            timeout   <= timeout_d;
            ptr       <= ptr_d;
            hold_q    <= hold_d;
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter (N_REQ=4, MAX_HOLD=4): directed scenarios plus random traffic.
// Latency: model is stepped at every rising edge; outputs are sampled 1 time unit later.
// Backpressure: not applicable; stimulus drives req/release_i directly.
module tb_rr_grant_arbiter;

    localparam int N = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0;
    logic       release_i = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;
    logic [1:0] ptr;
    logic [9:0] dut_vec;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: owner (-1 when none), cycles held so far, priority pointer, last owner.
    int   m_owner;
    int   m_age;
    int   m_ptr;
    int   m_last;
    logic m_to;

    always #5 clk = ~clk;

    rr_grant_arbiter #(.N_REQ(N), .MAX_HOLD(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .release_i (release_i),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout),
        .ptr       (ptr)
    );

    assign dut_vec = {gnt, gnt_idx, gnt_valid, timeout, ptr};

    function automatic logic [9:0] exp_vec();
        logic [3:0] g;
        g = (m_owner < 0) ? 4'b0 : (4'b0001 << m_owner);
        return {g, 2'(m_last), (m_owner >= 0), m_to, 2'(m_ptr)};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_ptr   = 0;
        m_last  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic rel);
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_ptr + i) % N;
                if (m_owner < 0 && r[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_age   = 1;
                end
            end
        end else if (rel || !r[m_owner] || m_age == H) begin
            m_to    = !rel && r[m_owner];
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else begin
            m_age = m_age + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(req, release_i);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b0;
        release_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (dut_vec !== 10'b0) $display("FAIL reset_state got %b want %b", dut_vec, 10'b0);
        else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total_cnt++;
            if (dut_vec !== 10'b0) $display("FAIL idle_no_req cyc%0d got %b want %b", k, dut_vec, 10'b0);
            else pass_cnt++;
        end
    endtask

    task automatic test_rotation();
        int exp_idx[5] = '{0, 1, 2, 3, 0};
        int exp_ptr[5] = '{1, 2, 3, 0, 1};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            total_cnt++;
            if ({gnt, gnt_idx, gnt_valid} !== {4'b0001 << exp_idx[k], 2'(exp_idx[k]), 1'b1})
                $display("FAIL rotation_grant#%0d got gnt=%b idx=%0d want idx=%0d", k, gnt, gnt_idx, exp_idx[k]);
            else pass_cnt++;
            release_i = 1'b1;
            tick();
            release_i = 1'b0;
            total_cnt++;
            if ({gnt, gnt_valid, timeout, ptr} !== {4'b0, 1'b0, 1'b0, 2'(exp_ptr[k])})
                $display("FAIL rotation_bubble#%0d got gnt=%b to=%b ptr=%0d want ptr=%0d", k, gnt, timeout, ptr, exp_ptr[k]);
            else pass_cnt++;
        end
        req = 4'b0;
        tick();
    endtask

    task automatic test_wrap();
        req = 4'b0010;
        tick();
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        total_cnt++;
        if ({gnt, ptr} !== {4'b0, 2'd2}) $display("FAIL wrap_setup got gnt=%b ptr=%0d want ptr=2", gnt, ptr);
        else pass_cnt++;
        req = 4'b0011;
        tick();
        total_cnt++;
        if (gnt !== 4'b0001) $display("FAIL wrap_first got %b want 0001", gnt);
        else pass_cnt++;
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        tick();
        total_cnt++;
        if ({gnt, ptr} !== {4'b0010, 2'd1}) $display("FAIL wrap_second got gnt=%b ptr=%0d want 0010/1", gnt, ptr);
        else pass_cnt++;
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        req = 4'b0;
        tick();
    endtask

    task automatic test_timeout();
        req = 4'b0100;
        for (int k = 0; k < H; k++) begin
            tick();
            total_cnt++;
            if ({gnt, timeout} !== {4'b0100, 1'b0}) $display("FAIL timeout_hold cyc%0d got gnt=%b to=%b want 0100/0", k, gnt, timeout);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if ({gnt, gnt_valid, timeout, ptr} !== {4'b0, 1'b0, 1'b1, 2'd3})
            $display("FAIL timeout_pulse got gnt=%b to=%b ptr=%0d want 0000/1/3", gnt, timeout, ptr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({gnt, timeout} !== {4'b0100, 1'b0}) $display("FAIL timeout_regrant got gnt=%b to=%b want 0100/0", gnt, timeout);
        else pass_cnt++;
        repeat (H - 1) tick();
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        total_cnt++;
        if ({gnt, timeout, ptr} !== {4'b0, 1'b0, 2'd3})
            $display("FAIL release_at_limit got gnt=%b to=%b ptr=%0d want 0000/0/3", gnt, timeout, ptr);
        else pass_cnt++;
        req = 4'b0;
        tick();
    endtask

    task automatic test_drop();
        req = 4'b0001;
        tick();
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        req = 4'b0010;
        tick();
        total_cnt++;
        if (gnt !== 4'b0010) $display("FAIL drop_setup got %b want 0010", gnt);
        else pass_cnt++;
        req = 4'b1010;
        tick();
        total_cnt++;
        if (gnt !== 4'b0010) $display("FAIL drop_no_preempt got %b want 0010", gnt);
        else pass_cnt++;
        req = 4'b1000;
        tick();
        total_cnt++;
        if ({gnt, timeout, ptr} !== {4'b0, 1'b0, 2'd2}) $display("FAIL drop_end got gnt=%b to=%b ptr=%0d want 0000/0/2", gnt, timeout, ptr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (gnt !== 4'b1000) $display("FAIL drop_next got %b want 1000", gnt);
        else pass_cnt++;
        release_i = 1'b1;
        req = 4'b0;
        tick();
        release_i = 1'b0;
    endtask

    task automatic test_async_reset();
        req = 4'b0010;
        tick();
        total_cnt++;
        if (gnt !== 4'b0010) $display("FAIL areset_setup got %b want 0010", gnt);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({gnt, gnt_valid, ptr} !== {4'b0, 1'b0, 2'd0}) $display("FAIL areset_immediate got gnt=%b vld=%b ptr=%0d want 0", gnt, gnt_valid, ptr);
        else pass_cnt++;
        model_reset();
        req = 4'b1110;
        @(negedge clk) rst_n = 1'b1;
        tick();
        total_cnt++;
        if ({gnt, gnt_idx} !== {4'b0010, 2'd1}) $display("FAIL areset_restart got gnt=%b idx=%0d want 0010/1", gnt, gnt_idx);
        else pass_cnt++;
        release_i = 1'b1;
        req = 4'b0;
        tick();
        release_i = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            for (int b = 0; b < N; b++) req[b] = ($urandom_range(7) != 0);
            release_i = ($urandom_range(5) == 0);
            tick();
            total_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL random_model cyc%0d got %b want %b", k, dut_vec, exp_vec());
            else pass_cnt++;
            total_cnt++;
            if (!$onehot0(gnt) || (gnt_valid !== (|gnt))) $display("FAIL random_onehot cyc%0d gnt=%b vld=%b", k, gnt, gnt_valid);
            else pass_cnt++;
        end
        req = 4'b0;
        release_i = 1'b0;
        tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rotation();
        test_wrap();
        test_timeout();
        test_drop();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
